// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: rebuilds pixel coordinates from incoming active-low
// hsync/vsync, measures line/frame periods and tracks timing lock.
module vga_sync_decoder #(
    parameter int H_DISP       = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_TOTAL      = 800,
    parameter int V_DISP       = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_TOTAL      = 525,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       p_tick,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] h_total,
    output logic [9:0] v_total,
    output logic       locked,
    output logic       sync_err
);

    localparam logic [9:0] HDisp      = 10'(H_DISP);
    localparam logic [9:0] HSyncStart = 10'(H_SYNC_START);
    localparam logic [9:0] HTotal     = 10'(H_TOTAL);
    localparam logic [9:0] HTotalM1   = 10'(H_TOTAL - 1);
    localparam logic [9:0] VDisp      = 10'(V_DISP);
    localparam logic [9:0] VSyncStart = 10'(V_SYNC_START);
    localparam logic [9:0] VTotal     = 10'(V_TOTAL);
    localparam logic [9:0] VTotalM1   = 10'(V_TOTAL - 1);
    localparam logic [9:0] CntMax     = 10'h3FF;
    localparam logic [3:0] LockFrames = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_e;

    logic hs_meta_q, hs_sync_q, hs_prev_q;
    logic vs_meta_q, vs_sync_q, vs_prev_q;

    logic [9:0] h_cnt_q, h_cnt_d, h_per_q, h_per_d, h_total_q, h_total_d;
    logic [9:0] v_cnt_q, v_cnt_d, v_per_q, v_per_d, v_total_q, v_total_d;
    logic [9:0] h_meas;
    logic       hfall, vfall, h_wrap, v_wrap, h_bad, v_bad;

    state_e     state_q, state_d;
    logic [3:0] good_cnt_q, good_cnt_d, good_inc;
    logic       lines_ok_q, lines_ok_d;
    logic       err_d;

    logic line_start_q, frame_start_q, sync_err_q, video_on_q;

    // Two-flop synchronizers plus a tick-rate history flop; idle level is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_meta_q <= 1'b1;
            hs_sync_q <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            hs_meta_q <= hsync_in;
            hs_sync_q <= hs_meta_q;
            vs_meta_q <= vsync_in;
            vs_sync_q <= vs_meta_q;
            if (p_tick) begin
                hs_prev_q <= hs_sync_q;
                vs_prev_q <= vs_sync_q;
            end
        end
    end

    assign hfall    = p_tick && hs_prev_q && !hs_sync_q;
    assign vfall    = p_tick && vs_prev_q && !vs_sync_q;
    assign h_wrap   = p_tick && !hfall && (h_cnt_q == HTotalM1);
    assign v_wrap   = h_wrap && !vfall && (v_cnt_q == VTotalM1);
    assign h_meas   = (h_per_q == CntMax) ? CntMax : h_per_q + 10'd1;
    assign h_bad    = hfall && (h_meas != HTotal);
    assign v_bad    = vfall && (v_per_q != VTotal);
    assign good_inc = good_cnt_q + 4'd1;

    // Coordinate counters and period measurement, advanced only on pixel ticks
    always_comb begin
        h_cnt_d   = h_cnt_q;
        h_per_d   = h_per_q;
        h_total_d = h_total_q;
        v_cnt_d   = v_cnt_q;
        v_per_d   = v_per_q;
        v_total_d = v_total_q;
        if (p_tick) begin
            if (hfall) begin
                h_cnt_d   = HSyncStart;
                h_per_d   = 10'd0;
                h_total_d = h_meas;
            end else begin
                h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
                if (h_per_q != CntMax) h_per_d = h_per_q + 10'd1;
            end
            if (vfall) begin
                v_cnt_d   = VSyncStart;
                v_total_d = v_per_q;
                // A line wrap landing on the vsync tick belongs to the new frame
                v_per_d   = h_wrap ? 10'd1 : 10'd0;
            end else if (h_wrap) begin
                v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
                if (v_per_q != CntMax) v_per_d = v_per_q + 10'd1;
            end
        end
    end

    // Lock FSM: one sync_err per offending tick; a tainted frame is not counted
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        lines_ok_d = lines_ok_q;
        err_d      = 1'b0;
        if (p_tick) begin
            case (state_q)
                SEARCH: begin
                    if (vfall) begin
                        state_d    = VERIFY;
                        good_cnt_d = 4'd0;
                        lines_ok_d = 1'b1;
                    end
                end
                default: begin
                    if (h_bad || v_bad) begin
                        err_d      = 1'b1;
                        state_d    = VERIFY;
                        good_cnt_d = 4'd0;
                        lines_ok_d = vfall;
                    end else if (vfall) begin
                        lines_ok_d = 1'b1;
                        if (lines_ok_q && state_q == VERIFY) begin
                            good_cnt_d = good_inc;
                            if (good_inc >= LockFrames) state_d = LOCKED;
                        end
                    end
                end
            endcase
        end
    end

    // State and output registers; all outputs clear immediately on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= 10'd0;
            h_per_q       <= 10'd0;
            h_total_q     <= 10'd0;
            v_cnt_q       <= 10'd0;
            v_per_q       <= 10'd0;
            v_total_q     <= 10'd0;
            state_q       <= SEARCH;
            good_cnt_q    <= 4'd0;
            lines_ok_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            video_on_q    <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            h_per_q       <= h_per_d;
            h_total_q     <= h_total_d;
            v_cnt_q       <= v_cnt_d;
            v_per_q       <= v_per_d;
            v_total_q     <= v_total_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            lines_ok_q    <= lines_ok_d;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            sync_err_q    <= err_d;
            video_on_q    <= (state_q == LOCKED) && (h_cnt_q < HDisp) && (v_cnt_q < VDisp);
        end
    end

    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;
    assign video_on    = video_on_q;
    assign locked      = (state_q == LOCKED);

endmodule
